// File: rtl/draw_pkg.sv
// ============================================================================
// draw_pkg: shared widths, screen bounds and FSM encoding for the draw path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package draw_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int S_W      = 5;
  localparam int C_W      = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [C_W-1:0] ERASE_COLOUR = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rect_scan_counter.sv
// ============================================================================
// rect_scan_counter: row-major col/row counter bounded by width/height.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rect_scan_counter
  import draw_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           enable,
  input  logic [S_W-1:0] width,
  input  logic [S_W-1:0] height,
  output logic [S_W-1:0] col,
  output logic [S_W-1:0] row,
  output logic           last
);

  logic [S_W-1:0] col_q, col_d;
  logic [S_W-1:0] row_q, row_d;
  logic           col_at_end;

  assign col_at_end = (col_q == width - S_W'(1));
  assign last       = col_at_end && (row_q == height - S_W'(1));

  // The count parks on the final pixel so the outputs hold it after the walk.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (enable && !last) begin
      if (col_at_end) begin
        col_d = '0;
        row_d = row_q + S_W'(1);
      end else begin
        col_d = col_q + S_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

`default_nettype wire

// File: rtl/rect_plotter.sv
// ============================================================================
// rect_plotter: rasterises one clipped rectangle per start, one pixel/cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rect_plotter
  import draw_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] start_x,
  input  logic [Y_W-1:0] start_y,
  input  logic [S_W-1:0] width,
  input  logic [S_W-1:0] height,
  input  logic [C_W-1:0] color,
  input  logic           erase,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  state_e         state_q, state_d;
  logic [X_W-1:0] sx_q, sx_d;
  logic [Y_W-1:0] sy_q, sy_d;
  logic [S_W-1:0] w_q, w_d;
  logic [S_W-1:0] h_q, h_d;
  logic [C_W-1:0] colour_q, colour_d;

  logic           accept;
  logic [S_W-1:0] col;
  logic [S_W-1:0] row;
  logic           last;
  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;

  assign accept = (state_q == IDLE) && start;

  rect_scan_counter u_scan (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state_q == DRAW),
    .width  (w_q),
    .height (h_q),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sx_q     <= '0;
      sy_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      w_q      <= w_d;
      h_q      <= h_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    w_d      = w_q;
    h_d      = h_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sx_d     = start_x;
          sy_d     = start_y;
          w_d      = width;
          h_d      = height;
          colour_d = erase ? ERASE_COLOUR : color;
          state_d  = (width == '0 || height == '0) ? DONE : DRAW;
        end
      end
      DRAW:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sums carry one extra bit so off-screen wrap cannot alias onto the screen.
  assign x_sum = {1'b0, sx_q} + {{(X_W + 1 - S_W){1'b0}}, col};
  assign y_sum = {1'b0, sy_q} + {{(Y_W + 1 - S_W){1'b0}}, row};

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    vga_x      = x_sum[X_W-1:0];
    vga_y      = y_sum[Y_W-1:0];
    vga_colour = colour_q;
    vga_plot   = (state_q == DRAW) &&
                 (x_sum < (X_W + 1)'(SCREEN_W)) &&
                 (y_sum < (Y_W + 1)'(SCREEN_H));
  end

endmodule

`default_nettype wire

// File: tb/tb_rect_plotter.sv
// ============================================================================
// tb_rect_plotter: table-driven rectangle vectors with a pixel scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] start_x;
  logic [6:0] start_y;
  logic [4:0] width;
  logic [4:0] height;
  logic [2:0] color;
  logic       erase;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  rect_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_x    (start_x),
    .start_y    (start_y),
    .width      (width),
    .height     (height),
    .color      (color),
    .erase      (erase),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sx;
    logic [6:0] sy;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] c;
    logic       e;
    int         ign_k;
    int         exp_plots;
  } vec_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scramble();
    start_x = 8'($urandom);
    start_y = 7'($urandom);
    width   = 5'($urandom);
    height  = 5'($urandom);
    color   = 3'($urandom);
    erase   = 1'($urandom);
  endtask

  // Called right after a negedge with the DUT idle; returns at the idle
  // negedge following the done cycle, so back-to-back calls start at N+WH+2.
  task automatic run_rect(input vec_t v);
    int         w = int'(v.w);
    int         h = int'(v.h);
    int         wh = w * h;
    int         plots = 0;
    int         xs, ys, idx;
    logic       exp_plot;
    logic [2:0] colr = v.e ? 3'd0 : v.c;
    pix_t       p;
    start   = 1'b1;
    start_x = v.sx;
    start_y = v.sy;
    width   = v.w;
    height  = v.h;
    color   = v.c;
    erase   = v.e;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        xs = int'(v.sx) + c;
        ys = int'(v.sy) + r;
        if (xs < 160 && ys < 120) sb.push_back('{8'(xs), 7'(ys), colr});
      end
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int k = 1; k <= wh + 1; k++) begin
      exp_plot = 1'b0;
      if (k <= wh) begin
        idx = k - 1;
        xs  = int'(v.sx) + idx % w;
        ys  = int'(v.sy) + idx / w;
        exp_plot = (xs < 160 && ys < 120);
      end
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(k == wh + 1));
      check("vga_plot", 32'(vga_plot), 32'(exp_plot));
      if (vga_plot) begin
        plots++;
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          p = sb.pop_front();
          check("vga_x", 32'(vga_x), 32'(p.x));
          check("vga_y", 32'(vga_y), 32'(p.y));
          check("vga_colour", 32'(vga_colour), 32'(p.c));
        end
      end
      if (k == v.ign_k) begin
        start   = 1'b1;
        start_x = 8'd1;
        start_y = 7'd1;
        width   = 5'd1;
        height  = 5'd1;
        color   = 3'd7;
        erase   = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
    check("plot_count", 32'(plots), 32'(v.exp_plots));
    check("sb_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vecs[8];
  vec_t v4;
  int   done_seen;

  initial begin
    vecs[0] = '{8'd10,  7'd20,  5'd2,  5'd3,  3'd5, 1'b0, 7, 6};
    vecs[1] = '{8'd5,   7'd5,   5'd0,  5'd7,  3'd3, 1'b0, 0, 0};
    vecs[2] = '{8'd158, 7'd118, 5'd4,  5'd4,  3'd2, 1'b0, 0, 4};
    vecs[3] = '{8'd30,  7'd40,  5'd3,  5'd3,  3'd1, 1'b0, 3, 9};
    vecs[4] = '{8'd0,   7'd0,   5'd31, 5'd31, 3'd6, 1'b1, 0, 961};
    vecs[5] = '{8'd150, 7'd100, 5'd20, 5'd25, 3'd3, 1'b0, 0, 200};
    vecs[6] = '{8'd255, 7'd127, 5'd2,  5'd2,  3'd4, 1'b0, 0, 0};
    vecs[7] = '{8'd9,   7'd9,   5'd5,  5'd0,  3'd4, 1'b0, 1, 0};

    reset = 1'b1;
    start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_x", 32'(vga_x), 32'd0);
    check("rst_y", 32'(vga_y), 32'd0);
    check("rst_colour", 32'(vga_colour), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_rect(vecs[i]);

    // Reset landing on pixel 5 of a 4x4 draw.
    v4 = '{8'd2, 7'd3, 5'd4, 5'd4, 3'd4, 1'b0, 0, 16};
    start = 1'b1;
    start_x = v4.sx; start_y = v4.sy; width = v4.w; height = v4.h;
    color = v4.c; erase = 1'b0;
    @(negedge clk);
    start = 1'b0;
    scramble();
    repeat (4) @(negedge clk);
    check("mid_plot", 32'(vga_plot), 32'd1);
    check("mid_x", 32'(vga_x), 32'd2);
    check("mid_y", 32'(vga_y), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    check("rr_plot", 32'(vga_plot), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_done", 32'(done), 32'd0);
    check("rr_x", 32'(vga_x), 32'd0);
    check("rr_colour", 32'(vga_colour), 32'd0);
    reset = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || vga_plot) done_seen++;
    end
    check("rr_quiet", 32'(done_seen), 32'd0);
    run_rect(v4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rect_plotter.md
# rect_plotter

Pixel-level rectangle rasteriser that sits directly downstream of the object display multiplexer in the space-shooter graphics path. It accepts one rectangle descriptor (origin, size, colour) per start pulse and walks it row-major, emitting one VGA-adapter pixel write per cycle. Pixels off the 160x120 screen are clipped. It reports completion with a one-cycle done pulse so the draw controller can advance to the next object.

## Interface
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- S_W, 5, width/height field width
- C_W, 3, colour width
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request to draw the current descriptor; sampled only in IDLE
- start_x  in  X_W  rectangle left column
- start_y  in  Y_W  rectangle top row
- width  in  S_W  rectangle width in pixels (0 = nothing to draw)
- height  in  S_W  rectangle height in pixels (0 = nothing to draw)
- color  in  C_W  fill colour
- erase  in  1  when high at start, fill with colour 0 instead of color
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of rectangle
- vga_x  out  X_W  pixel column
- vga_y  out  Y_W  pixel row
- vga_colour  out  C_W  pixel colour
- vga_plot  out  1  write enable for the VGA adapter

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: start=1 latches start_x, start_y, width, height, colour (0 if erase) into internal registers; clears col=0, row=0. Next state DRAW, or DONE directly if width==0 or height==0.
- DRAW: each cycle presents pixel (sx+col, sy+row). col increments; when col==w-1, col returns to 0 and row increments. When col==w-1 and row==h-1, next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE.
- Inputs are not observed after latching; upstream may change them once busy is high.
- start in DRAW or DONE is ignored (not queued).
- Clipping: x sum computed at X_W+1 bits, y sum at Y_W+1 bits. vga_plot=1 only in DRAW and only when x_sum<SCREEN_W and y_sum<SCREEN_H. Clipped pixels still consume their cycle. vga_x/vga_y carry the truncated sums.
- Outputs outside DRAW: vga_plot=0; vga_x, vga_y, vga_colour hold the last driven values (don't-care when vga_plot=0).
- Reset (any state, including mid-DRAW): state IDLE, col=row=0, all latched registers 0, busy=0, done=0, vga_plot=0, vga_x=vga_y=vga_colour=0.

## Timing
- start sampled at rising edge N in IDLE: busy high from cycle N+1.
- Pixels presented in cycles N+1 .. N+W*H, one per cycle, row-major (x fastest).
- done high in cycle N+W*H+1; busy low and new start accepted from cycle N+W*H+2.
- Zero-size rectangle: done in cycle N+1, no pixels; start accepted again from N+2.
- Worst case 31x31: 961 pixel cycles + 1 done cycle.
- vga_* are combinational from state and the col/row/latched registers; no output register stage.

## Structure
- Shared package draw_pkg: X_W, Y_W, S_W, C_W, SCREEN_W, SCREEN_H, state enum (IDLE, DRAW, DONE), ERASE_COLOUR=0.
- One sub-module: rect_scan_counter (col/row 2-D counter with clear, enable, width/height bounds, last-pixel flag). FSM, latches and clip logic stay in rect_plotter.

## Test plan
- start with (10,20), w=2, h=3, color=5 -> plots (10,20),(11,20),(10,21),(11,21),(10,22),(11,22) colour 5 in cycles N+1..N+6; done at N+7.
- width=0, height=7 -> no vga_plot, done at N+1, busy low at N+2.
- (158,118), w=4, h=4, colour 2 -> 16 pixel cycles, vga_plot high only for (158,118),(159,118),(158,119),(159,119); done at N+17.
- 3x3 draw, second start with different descriptor at N+4 -> ignored, exactly 9 pixels of the first descriptor; start after done cycle is accepted.
- reset asserted during pixel 5 of a 4x4 draw -> next cycle vga_plot=0, busy=0, done never pulses; fresh start then draws full 16 pixels.
- erase=1, color=6, 31x31 at (0,0) -> 961 plots all colour 0, last pixel (30,30), done at N+962.
